// File: rtl/fetch_unit.sv
// fetch_unit
//   Stage-1 instruction fetch for the 3-stage RV32 pipeline. Owns the PC, issues
//   in-order requests to a variable-latency imem, and buffers returned words
//   (with their PCs) in a small FIFO toward decode. After a redirect, any
//   responses to wrong-path requests are discarded.
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   pc_mux_sel                    PLUS_4 = sequential; BRANCH / J = redirect
//   branch_target, jump_target    redirect addresses for BRANCH / J
//   imem_req_valid/ready/addr     fetch request handshake (addr = pc)
//   imem_resp_valid/data          in-order response word
//   inst_valid/inst_ready         handshake toward decode
//   instruction, inst_pc          FIFO head and its PC; zero when !inst_valid

`ifndef PC_MUX_SEL_WIDTH
`define PC_MUX_SEL_WIDTH 2
`endif
`ifndef PC_MUX_PLUS_4
`define PC_MUX_PLUS_4 2'd0
`endif
`ifndef PC_MUX_BRANCH
`define PC_MUX_BRANCH 2'd1
`endif
`ifndef PC_MUX_J
`define PC_MUX_J 2'd2
`endif

module fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h1000_0000,
   parameter int unsigned FIFO_DEPTH = 2,
   parameter int unsigned CNT_W      = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [`PC_MUX_SEL_WIDTH-1:0] pc_mux_sel,
   input  logic [31:0]                  branch_target,
   input  logic [31:0]                  jump_target,
   output logic                         imem_req_valid,
   input  logic                         imem_req_ready,
   output logic [31:0]                  imem_req_addr,
   input  logic                         imem_resp_valid,
   input  logic [31:0]                  imem_resp_data,
   output logic                         inst_valid,
   input  logic                         inst_ready,
   output logic [31:0]                  instruction,
   output logic [31:0]                  inst_pc
);

   localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   logic [31:0]      pc;
   logic [31:0]      resp_pc;      // PC of the next response that will be kept
   logic [CNT_W-1:0] outstanding;
   logic [CNT_W-1:0] drop_cnt;
   logic [CNT_W-1:0] count;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [31:0]      fifo_data [FIFO_DEPTH];
   logic [31:0]      fifo_pc   [FIFO_DEPTH];

   logic             redirect;
   logic [31:0]      redirect_target;
   logic [CNT_W:0]   in_use;
   logic             accept;
   logic             push;
   logic             drop;
   logic             pop;

   always_comb begin
      redirect        = (pc_mux_sel != `PC_MUX_PLUS_4);
      redirect_target = (pc_mux_sel == `PC_MUX_J) ? jump_target : branch_target;
      redirect_target = {redirect_target[31:2], 2'b00};

      // Credits cover both in-flight and buffered words, so the FIFO can't overflow.
      in_use          = {1'b0, outstanding} + {1'b0, count};
      imem_req_valid  = !rst && !redirect && (in_use < (CNT_W+1)'(FIFO_DEPTH));
      imem_req_addr   = pc;
      accept          = imem_req_valid && imem_req_ready;

      drop            = imem_resp_valid && (redirect || (drop_cnt != '0));
      push            = imem_resp_valid && !drop;

      inst_valid      = !rst && !redirect && (count != '0);
      pop             = inst_valid && inst_ready;
      instruction     = inst_valid ? fifo_data[rd_ptr] : '0;
      inst_pc         = inst_valid ? fifo_pc[rd_ptr]   : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc          <= RESET_PC;
         resp_pc     <= RESET_PC;
         outstanding <= '0;
         drop_cnt    <= '0;
         count       <= '0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
      end else begin
         outstanding <= outstanding + CNT_W'(accept) - CNT_W'(imem_resp_valid);
         if (redirect) begin
            // Every request still in flight after this cycle is wrong-path,
            // including ones already marked for dropping.
            pc       <= redirect_target;
            resp_pc  <= redirect_target;
            drop_cnt <= outstanding - CNT_W'(imem_resp_valid);
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
         end else begin
            if (accept)
               pc <= pc + 32'd4;
            if (drop)
               drop_cnt <= drop_cnt - 1'b1;
            if (push) begin
               fifo_data[wr_ptr] <= imem_resp_data;
               fifo_pc[wr_ptr]   <= resp_pc;
               resp_pc           <= resp_pc + 32'd4;
               wr_ptr            <= (wr_ptr == PTR_W'(FIFO_DEPTH-1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop)
               rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH-1)) ? '0 : rd_ptr + 1'b1;
            count <= count + CNT_W'(push) - CNT_W'(pop);
         end
      end
   end

   no_fifo_overflow: assert property (@(posedge clk) disable iff (rst)
      (push && !pop) |-> (count < CNT_W'(FIFO_DEPTH)));

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit
//   Randomized bench for fetch_unit. A behavioural imem returns words in order
//   with random latency; a reference model tags each request with a redirect
//   epoch and keeps only same-epoch words, predicting the request stream and
//   the instruction stream seen by decode.

`ifndef PC_MUX_SEL_WIDTH
`define PC_MUX_SEL_WIDTH 2
`endif
`ifndef PC_MUX_PLUS_4
`define PC_MUX_PLUS_4 2'd0
`endif
`ifndef PC_MUX_BRANCH
`define PC_MUX_BRANCH 2'd1
`endif
`ifndef PC_MUX_J
`define PC_MUX_J 2'd2
`endif

module tb_fetch_unit;

   localparam logic [31:0] RESET_PC   = 32'h1000_0000;
   localparam int unsigned FIFO_DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  pc_mux_sel;
   logic [31:0] branch_target, jump_target;
   logic        imem_req_valid, imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        inst_valid, inst_ready;
   logic [31:0] instruction, inst_pc;

   fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(2)) dut (
      .clk(clk), .rst(rst), .pc_mux_sel(pc_mux_sel),
      .branch_target(branch_target), .jump_target(jump_target),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_req_addr(imem_req_addr), .imem_resp_valid(imem_resp_valid),
      .imem_resp_data(imem_resp_data), .inst_valid(inst_valid),
      .inst_ready(inst_ready), .instruction(instruction), .inst_pc(inst_pc)
   );

   always #5 clk = ~clk;

   typedef struct { logic [31:0] addr; int unsigned epoch; int unsigned due; } req_t;
   typedef struct { logic [31:0] data; logic [31:0] pc; } word_t;

   req_t        inflight[$];   // accepted by imem, not yet responded
   word_t       mq[$];         // words decode should still see, in order
   logic [31:0] req_pc = RESET_PC;
   int unsigned epoch = 0;
   int unsigned cyc = 0;
   int unsigned n_cmp = 0;
   int unsigned n_err = 0;
   int unsigned lat_min = 1, lat_max = 1, p_ready = 100, p_ir = 100;

   function automatic logic [31:0] imem_word(input logic [31:0] a);
      return {a[7:0], a[31:8]} ^ 32'hDEAD_BEEF;
   endfunction

   function automatic logic [31:0] rand_tgt();
      if ($urandom_range(3) == 0) return 32'hFFFF_FFF0 | 32'($urandom_range(15));
      return RESET_PC + 32'($urandom_range(255));
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
      end
   endtask

   task automatic cycle(input logic r, input logic [1:0] sel, input logic [31:0] tgt);
      logic        redir, exp_rv, exp_iv, acc, rv;
      logic [31:0] target;
      req_t        e;
      exp_iv = 1'b0;
      @(negedge clk);
      rst            = r;
      pc_mux_sel     = sel;
      branch_target  = (sel == `PC_MUX_BRANCH) ? tgt : $urandom;
      jump_target    = (sel == `PC_MUX_J)      ? tgt : $urandom;
      imem_req_ready = ($urandom_range(99) < p_ready);
      inst_ready     = ($urandom_range(99) < p_ir);
      rv = !r && (inflight.size() > 0) && (inflight[0].due <= cyc);
      imem_resp_valid = rv;
      imem_resp_data  = rv ? imem_word(inflight[0].addr) : $urandom;
      #1;
      redir  = (sel != `PC_MUX_PLUS_4);
      target = (sel == `PC_MUX_J) ? jump_target : branch_target;
      exp_rv = !r && !redir && (inflight.size() + mq.size() < FIFO_DEPTH);
      check("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_rv});
      if (exp_rv) check("req_addr", imem_req_addr, req_pc);
      if (!r) begin
         exp_iv = !redir && (mq.size() > 0);
         check("inst_valid", {31'b0, inst_valid}, {31'b0, exp_iv});
         check("instruction", instruction, exp_iv ? mq[0].data : 32'h0);
         check("inst_pc", inst_pc, exp_iv ? mq[0].pc : 32'h0);
      end
      acc = exp_rv && imem_req_ready;
      @(posedge clk);
      if (r) begin
         inflight.delete();
         mq.delete();
         req_pc = RESET_PC;
         epoch++;
      end else begin
         if (exp_iv && inst_ready) void'(mq.pop_front());
         if (rv) begin
            e = inflight.pop_front();
            if (!redir && e.epoch == epoch) mq.push_back('{imem_word(e.addr), e.addr});
         end
         if (acc) begin
            inflight.push_back('{req_pc, epoch, cyc + $urandom_range(lat_max, lat_min)});
            req_pc += 32'd4;
         end
         if (redir) begin
            mq.delete();
            epoch++;
            req_pc = {target[31:2], 2'b00};
         end
      end
      cyc++;
   endtask

   task automatic run(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) cycle(1'b0, `PC_MUX_PLUS_4, 32'h0);
   endtask

   initial begin
      logic       r;
      logic [1:0] s;
      rst = 1'b1; pc_mux_sel = `PC_MUX_PLUS_4; branch_target = '0; jump_target = '0;
      imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0; inst_ready = 1'b0;

      // reset, then streaming with a 1-cycle imem
      cycle(1'b1, `PC_MUX_PLUS_4, 32'h0);
      cycle(1'b1, `PC_MUX_PLUS_4, 32'h0);
      run(20);

      // decode stall for 6 cycles, then release
      p_ir = 0;   run(6);
      p_ir = 100; run(10);

      // branch while two requests are outstanding on a 3-cycle imem
      lat_min = 3; lat_max = 3;
      run(4);
      cycle(1'b0, `PC_MUX_BRANCH, 32'h1000_0102);
      run(12);

      // back-to-back jumps: the second target wins
      cycle(1'b0, `PC_MUX_J, 32'h1000_0040);
      cycle(1'b0, `PC_MUX_J, 32'h1000_0080);
      run(12);

      // redirect while a response arrives and the buffer is filling
      lat_min = 2; lat_max = 2; p_ir = 0;
      cycle(1'b0, `PC_MUX_J, 32'h1000_0200);
      run(3);
      cycle(1'b0, `PC_MUX_BRANCH, 32'h1000_0300);
      p_ir = 100; run(10);

      // reset pulse with words in flight and a full buffer
      lat_min = 3; lat_max = 3; p_ir = 0;
      run(6);
      cycle(1'b1, `PC_MUX_PLUS_4, 32'h0);
      p_ir = 100; lat_min = 1; lat_max = 1;
      run(10);

      // pc wrap-around
      cycle(1'b0, `PC_MUX_J, 32'hFFFF_FFF5);
      run(10);

      // randomized traffic
      for (int unsigned blk = 0; blk < 10; blk++) begin
         lat_min = $urandom_range(2, 1);
         lat_max = lat_min + $urandom_range(3);
         p_ready = $urandom_range(100, 30);
         p_ir    = $urandom_range(100, 20);
         for (int unsigned i = 0; i < 300; i++) begin
            r = ($urandom_range(99) < 2);
            s = `PC_MUX_PLUS_4;
            if ($urandom_range(99) < 10) s = $urandom_range(1) ? `PC_MUX_BRANCH : `PC_MUX_J;
            cycle(r, s, rand_tgt());
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
